// File: rtl/ysyx_23060203_axi_pkg.sv
// Shared AXI read-channel types for the burst ROM and its address helper.
package ysyx_23060203_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Only 4-byte beats are served.
    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_WAIT = 3'b010,
        ST_BEAT = 3'b100
    } state_e;

    // Legal WRAP lengths are 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/ysyx_23060203_axi_burst_addr.sv
// Combinational AXI next-beat address for 4-byte FIXED/INCR/WRAP bursts.
module ysyx_23060203_axi_burst_addr
    import ysyx_23060203_axi_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [7:0]  len_i,
    input  logic [1:0]  burst_i,
    output logic [31:0] next_addr_o
);

    logic [31:0] mask_c;
    logic [31:0] incr_c;

    // Reserved burst type 2'b11 holds the address like FIXED.
    always_comb begin
        mask_c = ((32'(len_i) + 32'd1) << 2) - 32'd1;
        incr_c = addr_i + 32'd4;
        case (burst_e'(burst_i))
            BURST_INCR: next_addr_o = incr_c;
            BURST_WRAP: next_addr_o = (addr_i & ~mask_c) | (incr_c & mask_c);
            default:    next_addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/ysyx_23060203_burst_rom.sv
// AXI4 read-only burst responder over a word-addressed on-chip memory.
// Optional feature macro: YSYX_23060203_ROM_RAND_LAT_EN (LFSR-randomised
// first-beat latency and inter-beat bubbles).
module ysyx_23060203_burst_rom
    import ysyx_23060203_axi_pkg::*;
#(
    parameter int unsigned DEPTH_W = 12,
    parameter logic [31:0] BASE    = 32'h3000_0000,
    parameter int unsigned LAT     = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               arvalid,
    output logic               arready,
    input  logic [31:0]        araddr,
    input  logic [3:0]         arid,
    input  logic [7:0]         arlen,
    input  logic [2:0]         arsize,
    input  logic [1:0]         arburst,
    output logic               rvalid,
    input  logic               rready,
    output logic [31:0]        rdata,
    output logic [1:0]         rresp,
    output logic               rlast,
    output logic [3:0]         rid,
    input  logic               wen,
    input  logic [DEPTH_W-1:0] waddr,
    input  logic [31:0]        wdata
);

    localparam int unsigned WORDS  = 2 ** DEPTH_W;
    localparam int unsigned ADDR_W = DEPTH_W + 2;
    localparam logic [7:0]  LAT_B  = 8'(LAT);

    logic [31:0] mem [WORDS];

    state_e      state_q;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [1:0]  burst_q;
    logic        err_q;
    logic [7:0]  cnt_q;
    logic [7:0]  dly_q;

    logic        arready_q;
    logic        rvalid_q;
    logic        rlast_q;
    logic [1:0]  rresp_q;
    logic [3:0]  rid_q;
    logic [31:0] rdata_q;

    logic               ar_hs_c;
    logic               r_hs_c;
    logic [31:0]        ar_off_c;
    logic               ar_err_c;
    logic [31:0]        next_addr_c;
    logic [31:0]        pres_addr_c;
    logic               pres_err_c;
    logic [31:0]        pres_off_c;
    logic [DEPTH_W-1:0] pres_idx_c;
    logic               beat_bad_c;
    logic [31:0]        beat_data_c;
    logic [1:0]         beat_resp_c;
    logic [7:0]         lat_c;
    logic               bubble_c;

`ifdef YSYX_23060203_ROM_RAND_LAT_EN
    logic [7:0] lfsr_q;

    // Fibonacci LFSR, taps 8,6,5,4, free-running.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr_q <= 8'h5A;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign lat_c    = LAT_B + {5'd0, lfsr_q[2:0]};
    assign bubble_c = lfsr_q[7];
`else
    assign lat_c    = LAT_B;
    assign bubble_c = 1'b0;
`endif

    ysyx_23060203_axi_burst_addr u_next_addr (
        .addr_i      (addr_q),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr_c)
    );

    // Handshakes, request checking and the data for whichever beat is shown next cycle.
    always_comb begin
        ar_hs_c  = (state_q == ST_IDLE) && arvalid && arready_q;
        r_hs_c   = (state_q == ST_BEAT) && rvalid_q && rready;
        ar_off_c = araddr - BASE;
        ar_err_c = (arsize != SIZE_WORD)
                || (araddr[1:0] != 2'b00)
                || (arburst == 2'b11)
                || ((arburst == BURST_WRAP) && !wrap_len_ok(arlen))
                || ((ar_off_c >> ADDR_W) != 32'd0);

        if (state_q == ST_IDLE) begin
            pres_addr_c = araddr;
            pres_err_c  = ar_err_c;
        end else begin
            pres_addr_c = r_hs_c ? next_addr_c : addr_q;
            pres_err_c  = err_q;
        end

        pres_off_c = pres_addr_c - BASE;
        pres_idx_c = pres_off_c[ADDR_W-1:2];
        beat_bad_c = pres_err_c || ((pres_off_c >> ADDR_W) != 32'd0);

        // A write landing on this edge is forwarded so the next beat sees it.
        if (beat_bad_c) begin
            beat_data_c = 32'd0;
        end else if (wen && (waddr == pres_idx_c)) begin
            beat_data_c = wdata;
        end else begin
            beat_data_c = mem[pres_idx_c];
        end
        beat_resp_c = beat_bad_c ? RESP_SLVERR : RESP_OKAY;
    end

    // Preload / patch port, usable in any state; contents are not reset.
    always_ff @(posedge clock) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    // Burst FSM with registered R-channel and AR-ready outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= 32'd0;
            len_q     <= 8'd0;
            burst_q   <= 2'b00;
            err_q     <= 1'b0;
            cnt_q     <= 8'd0;
            dly_q     <= 8'd0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= 4'd0;
            rdata_q   <= 32'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs_c) begin
                        arready_q <= 1'b0;
                        addr_q    <= araddr;
                        len_q     <= arlen;
                        burst_q   <= arburst;
                        err_q     <= ar_err_c;
                        cnt_q     <= arlen;
                        dly_q     <= lat_c;
                        rid_q     <= arid;
                        if (lat_c == 8'd0) begin
                            state_q  <= ST_BEAT;
                            rvalid_q <= 1'b1;
                            rlast_q  <= (arlen == 8'd0);
                            rdata_q  <= beat_data_c;
                            rresp_q  <= beat_resp_c;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    dly_q <= dly_q - 8'd1;
                    if (dly_q == 8'd1) begin
                        state_q  <= ST_BEAT;
                        rvalid_q <= 1'b1;
                        rlast_q  <= (cnt_q == 8'd0);
                        rdata_q  <= beat_data_c;
                        rresp_q  <= beat_resp_c;
                    end
                end
                ST_BEAT: begin
                    if (r_hs_c) begin
                        if (cnt_q == 8'd0) begin
                            state_q   <= ST_IDLE;
                            arready_q <= 1'b1;
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rresp_q   <= RESP_OKAY;
                        end else begin
                            cnt_q    <= cnt_q - 8'd1;
                            addr_q   <= next_addr_c;
                            rvalid_q <= !bubble_c;
                            rlast_q  <= (cnt_q == 8'd1);
                            rdata_q  <= beat_data_c;
                            rresp_q  <= beat_resp_c;
                        end
                    end else begin
                        // Stalled or in a bubble: keep presenting the current beat.
                        rvalid_q <= 1'b1;
                        rdata_q  <= beat_data_c;
                        rresp_q  <= beat_resp_c;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rresp   = rresp_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_ysyx_23060203_burst_rom.sv
// Directed scoreboard bench for ysyx_23060203_burst_rom (default build).
module tb_ysyx_23060203_burst_rom;

    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam int          DEPTH_W = 12;
    localparam logic [31:0] TOP     = 32'h3000_4000;

    logic              clock = 1'b0;
    logic              reset;
    logic              arvalid;
    logic              arready;
    logic [31:0]       araddr;
    logic [3:0]        arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [3:0]        rid;
    logic              wen;
    logic [DEPTH_W-1:0] waddr;
    logic [31:0]       wdata;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    beat_t       q[$];
    logic [31:0] mdl [0:4095];
    int          total = 0;
    int          bad   = 0;
    int          lat;

    ysyx_23060203_burst_rom #(
        .DEPTH_W (DEPTH_W),
        .BASE    (BASE),
        .LAT     (2)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .arid    (arid),
        .arlen   (arlen),
        .arsize  (arsize),
        .arburst (arburst),
        .rvalid  (rvalid),
        .rready  (rready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rid     (rid),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s timeout", tag);
    endtask

    function automatic logic [31:0] val(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0101_0003;
    endfunction

    task automatic wr(input int idx, input logic [31:0] d);
        wen   = 1'b1;
        waddr = DEPTH_W'(idx);
        wdata = d;
        tick();
        wen = 1'b0;
        mdl[idx] = d;
    endtask

    // Independent reference: compute every beat of a burst and queue it.
    task automatic push_burst(input logic [31:0] a0, input logic [3:0] id, input logic [7:0] len,
                              input logic [2:0] sz, input logic [1:0] bt);
        logic [31:0] a;
        logic [31:0] span;
        logic [31:0] lo;
        logic        err;
        logic        badb;
        beat_t       b;
        a    = a0;
        span = (32'(len) + 32'd1) * 32'd4;
        err  = (sz != 3'b010) || (a0[1:0] != 2'b00) || (bt == 2'b11)
            || (bt == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            || (a0 < BASE) || (a0 >= TOP);
        for (int k = 0; k <= int'(len); k++) begin
            badb   = err || (a < BASE) || (a >= TOP);
            b.data = badb ? 32'd0 : mdl[(a - BASE) / 4];
            b.resp = badb ? 2'b10 : 2'b00;
            b.last = (k == int'(len));
            b.id   = id;
            q.push_back(b);
            if (bt == 2'b01) begin
                a = a + 32'd4;
            end else if (bt == 2'b10) begin
                lo = a - (a % span);
                a  = lo + ((a - lo + 32'd4) % span);
            end
        end
    endtask

    task automatic ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                      input logic [2:0] sz, input logic [1:0] bt);
        int g = 0;
        push_burst(a, id, len, sz, bt);
        arvalid = 1'b1;
        araddr  = a;
        arid    = id;
        arlen   = len;
        arsize  = sz;
        arburst = bt;
        while (!arready && g < 50) begin
            tick();
            g++;
        end
        if (!arready) timeout("ar_accept");
        tick();
        arvalid = 1'b0;
        chk("arready_busy", 32'(arready), 32'd0);
    endtask

    // Accept n beats; pat gives rready per valid cycle (LSB first, then 1s).
    task automatic drain(input int n, input logic [15:0] pat, output int first_lat);
        int    got   = 0;
        int    cyc   = 1;
        int    k     = 0;
        int    guard = 0;
        bit    seen  = 1'b0;
        beat_t e;
        first_lat = -1;
        while (got < n && guard < 300) begin
            if (rvalid) begin
                if (!seen) begin
                    seen      = 1'b1;
                    first_lat = cyc;
                end
                rready = (k < 16) ? pat[k] : 1'b1;
                k++;
                if (q.size() == 0) begin
                    timeout("extra_beat");
                end else begin
                    e = q[0];
                    chk("rdata", rdata, e.data);
                    chk("rresp", 32'(rresp), 32'(e.resp));
                    chk("rlast", 32'(rlast), 32'(e.last));
                    chk("rid", 32'(rid), 32'(e.id));
                    if (rready) begin
                        void'(q.pop_front());
                        got++;
                    end
                end
            end
            tick();
            cyc++;
            guard++;
        end
        if (got < n) timeout("drain");
    endtask

    initial begin
        reset   = 1'b0;
        arvalid = 1'b0;
        araddr  = 32'd0;
        arid    = 4'd0;
        arlen   = 8'd0;
        arsize  = 3'b010;
        arburst = 2'b01;
        rready  = 1'b1;
        wen     = 1'b0;
        waddr   = '0;
        wdata   = 32'd0;

        tick();
        tick();
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_rid", 32'(rid), 32'd0);
        reset = 1'b1;
        tick();
        chk("rel_arready", 32'(arready), 32'd1);

        for (int i = 0; i < 16; i++) wr(i, val(i));
        wr(4094, val(4094));
        wr(4095, val(4095));

        // INCR 4 beats from word 4, latency check.
        ar(BASE + 32'h10, 4'h3, 8'd3, 3'b010, 2'b01);
        drain(4, 16'hFFFF, lat);
        chk("incr_lat", 32'(lat), 32'd3);
        chk("incr_arready_after", 32'(arready), 32'd1);

        // WRAP 8 beats from word 5.
        ar(BASE + 32'h14, 4'h5, 8'd7, 3'b010, 2'b10);
        drain(8, 16'hFFFF, lat);
        chk("wrap_lat", 32'(lat), 32'd3);
        chk("wrap_arready_after", 32'(arready), 32'd1);

        // Illegal WRAP length and illegal size.
        ar(BASE + 32'h08, 4'h7, 8'd2, 3'b010, 2'b10);
        drain(3, 16'hFFFF, lat);
        ar(BASE + 32'h00, 4'h8, 8'd2, 3'b001, 2'b01);
        drain(3, 16'hFFFF, lat);

        // rready 1,0,0,1 during INCR len 3.
        ar(BASE + 32'h00, 4'h9, 8'd3, 3'b010, 2'b01);
        drain(4, 16'hFFF9, lat);

        // Patch word 6 while it is presented and stalled.
        ar(BASE + 32'h10, 4'hA, 8'd3, 3'b010, 2'b01);
        drain(2, 16'hFFFF, lat);
        rready = 1'b0;
        wen    = 1'b1;
        waddr  = DEPTH_W'(6);
        wdata  = 32'hDEAD_BEEF;
        chk("patch_old", rdata, val(6));
        chk("patch_valid", 32'(rvalid), 32'd1);
        tick();
        wen = 1'b0;
        mdl[6] = 32'hDEAD_BEEF;
        q[0].data = 32'hDEAD_BEEF;
        chk("patch_new", rdata, 32'hDEAD_BEEF);
        drain(2, 16'hFFFF, lat);

        // INCR crossing the top of the array.
        ar(BASE + 32'h3FF8, 4'hB, 8'd3, 3'b010, 2'b01);
        drain(4, 16'hFFFF, lat);

        // Start address past the top.
        ar(TOP, 4'hC, 8'd0, 3'b010, 2'b01);
        drain(1, 16'hFFFF, lat);

        // Reset during beat 2 of 4, then a FIXED 2-beat burst.
        ar(BASE + 32'h00, 4'hD, 8'd3, 3'b010, 2'b01);
        drain(1, 16'hFFFF, lat);
        reset = 1'b0;
        tick();
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_rlast", 32'(rlast), 32'd0);
        chk("midrst_arready", 32'(arready), 32'd0);
        chk("midrst_rid", 32'(rid), 32'd0);
        reset = 1'b1;
        q.delete();
        tick();
        chk("midrst_arready_rel", 32'(arready), 32'd1);
        ar(BASE + 32'h20, 4'hE, 8'd1, 3'b010, 2'b00);
        drain(2, 16'hFFFF, lat);
        chk("fixed_lat", 32'(lat), 32'd3);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060203_burst_rom.md
# ysyx_23060203_burst_rom

AXI4 read-only burst responder backed by a word-addressed on-chip memory; the target end of the instruction-fetch refill path. It accepts one AR request at a time, then returns the FIXED, INCR or WRAP burst on R with a configurable first-beat latency. A simple write port preloads and patches the contents. It serves as the memory model for bench and FPGA builds of the fetch path.

## Interface
- `DEPTH_W`, 12: memory holds 2^DEPTH_W 32-bit words.
- `BASE`, 32'h3000_0000: byte address of word 0.
- `LAT`, 2: cycles from AR handshake to first `rvalid`; 0 is legal.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low; 0 at a rising edge resets.
- `arvalid`  in  1  AR request valid.
- `arready`  out  1  AR accept.
- `araddr`  in  32  start byte address.
- `arid`  in  4  transaction ID.
- `arlen`  in  8  beats minus 1.
- `arsize`  in  3  only 3'b010 supported.
- `arburst`  in  2  FIXED, INCR or WRAP.
- `rvalid`  out  1  beat valid.
- `rready`  in  1  beat accept.
- `rdata`  out  32  beat data.
- `rresp`  out  2  OKAY 2'b00 or SLVERR 2'b10.
- `rlast`  out  1  final beat.
- `rid`  out  4  equals the latched `arid`.
- `wen`  in  1  preload write strobe.
- `waddr`  in  DEPTH_W  preload word index.
- `wdata`  in  32  preload word.

## Operation
- States are one-hot: IDLE, WAIT, BEAT.
- IDLE: `arready`=1. `arvalid & arready` latches addr, id, len, burst and the error flag, loads the beat counter with `arlen` and the delay counter with the latency. Next state is WAIT if latency>0, otherwise BEAT.
- WAIT: the delay counter decrements each cycle. At 1 the next state is BEAT.
- BEAT: `rvalid`=1 and `rdata`=mem[(addr_r-BASE)>>2]. On `rvalid & rready`:
  - If the beat counter is 0, return to IDLE.
  - Otherwise decrement the counter and advance the address.
- Address advance:
  - FIXED: unchanged.
  - INCR: +4.
  - WRAP: with mask=(len+1)*4-1, next=(addr & ~mask) | ((addr+4) & mask).
- The error flag sets when any of the following holds:
  - `arsize`≠3'b010.
  - `araddr[1:0]`≠0.
  - `arburst`==2'b11.
  - WRAP with `arlen`∉{1,3,7,15}.
  - Start address outside [BASE, BASE+4·2^DEPTH_W).
- An errored burst still returns `arlen`+1 beats, each with `rresp`=SLVERR and `rdata`=0.
- An INCR beat crossing the top of the array returns SLVERR and `rdata`=0 for that beat only.
- `rlast` = BEAT & (beat counter==0).
- Preload write: `wen` updates mem[waddr] at the clock edge, in any state.
- A beat presented in the same cycle as a write to its word returns the old data. Beats in later cycles return the new data.

## Timing
- Reset values: `arready`=0 while `reset`=0, then 1 in the first cycle after release. `rvalid`=0, `rlast`=0, `rresp`=0, `rid`=0. Memory contents are not reset.
- AR to first `rvalid` is LAT+1 cycles, counted from the handshake edge. With LAT=0, `rvalid` rises the cycle after the handshake.
- Beats are back-to-back while `rready`=1. While `rready`=0, `rvalid`, `rdata`, `rresp` and `rlast` hold stable.
- `arready`=0 outside IDLE; there is no AR pipelining.
- After the `rlast` handshake, `arready`=1 on the next cycle. The minimum gap between bursts is therefore 1 cycle.
- Reset asserted mid-burst: the next edge forces IDLE and clears all outputs. The remaining beats are dropped.

## Configuration
- `YSYX_23060203_ROM_RAND_LAT_EN`
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'h5A at reset) advances every cycle.
  - Latency = LAT + lfsr[2:0], sampled at the AR handshake.
  - `rvalid` additionally deasserts for one cycle after any accepted beat when lfsr[7]=1.
- Undefined: fixed latency LAT and no inter-beat bubbles.

## Structure
- Package `ysyx_23060203_axi_pkg` holds:
  - Burst enum: FIXED 2'b00, INCR 2'b01, WRAP 2'b10.
  - Response constants: OKAY, SLVERR.
  - State enum.
- Sub-module `ysyx_23060203_axi_burst_addr`: combinational next-address calculator (addr, len, burst → next_addr). The ICache bench reuses it as its reference model.

## Test plan
- INCR, araddr=BASE+0x10, arlen=3, `rready`=1, LAT=2: first `rvalid` 3 cycles after AR. Four back-to-back beats from word indices 4,5,6,7; `rlast` on beat 4 only; `rid`=`arid`.
- WRAP, araddr=BASE+0x14, arlen=7: word order 5,6,7,0,1,2,3,4, then `arready`=1 one cycle after `rlast`.
- WRAP with arlen=2: three SLVERR beats, `rdata`=0. arsize=3'b001: SLVERR on every beat of the burst.
- `rready` toggled 1,0,0,1 during an INCR len 3 burst: data and `rlast` held while stalled; all four words delivered in order.
- `wen` to word 6 in the cycle word 6 is presented, with `rready`=0: that cycle shows the old value; the following cycle shows the new value.
- `reset`=0 during beat 2 of 4: `rvalid`=0 next cycle, `arready`=1 one cycle after release. A fresh FIXED len 1 burst then returns the same word twice.
